xor_share_ctrl: RTL and testbench

Round-robin scheduler that shares one 1-bit XOR cell among NREQ requesters, each submitting a pair of WIDTH-bit operands. It grants one requester at a time, captures its operands, and streams them LSB-first through the single cell over WIDTH cycles. It then presents the assembled WIDTH-bit XOR result with a one-cycle done pulse. It sits between client blocks and the team's bit-level XOR datapath, trading throughput for a single shared gate.

---
 rtl/xor_share_ctrl.sv | 165 ++++++++++++++++
 tb/tb_xor_share_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/xor_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : xor_share_ctrl
//  Purpose  : Round-robin scheduler sharing one bit-serial XOR cell among
//             NREQ requesters; results are assembled LSB-first over WIDTH cycles.
//  Revision : 1.0  initial release
// ============================================================================
module xor_share_ctrl #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      result
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int             IW       = IDW + 1;
    localparam logic [CW-1:0]  C_LAST   = CW'(WIDTH - 1);
    localparam logic [IDW-1:0] C_TOP_ID = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    win_q, win_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [IDW-1:0]    done_id_q, done_id_d;

    logic              w_any;
    logic [IDW-1:0]    w_pick;
    logic [IW-1:0]     w_idx;
    logic [WIDTH-1:0]  w_a_sel;
    logic [WIDTH-1:0]  w_b_sel;
    logic              w_c;
    logic [WIDTH-1:0]  w_res_shift;

    // Scan requesters starting at ptr, wrapping modulo NREQ; first hit wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, ptr_q} + IW'(k);
            if (w_idx >= IW'(NREQ)) begin
                w_idx = w_idx - IW'(NREQ);
            end
            if (!w_any && req[w_idx[IDW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_idx[IDW-1:0];
            end
        end
    end

    assign w_a_sel = a_in[int'(w_pick)*WIDTH +: WIDTH];
    assign w_b_sel = b_in[int'(w_pick)*WIDTH +: WIDTH];

    // The single shared 1-bit XOR cell.
    assign w_c = (sa_q[0] & ~sb_q[0]) | (~sa_q[0] & sb_q[0]);

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_shift = w_c;
        end else begin : g_res_wn
            assign w_res_shift = {w_c, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        res_d     = res_q;
        result_d  = result_q;
        done_id_d = done_id_q;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d        = SHIFT;
                    gnt_d          = '0;
                    gnt_d[w_pick]  = 1'b1;
                    win_d          = w_pick;
                    sa_d           = w_a_sel;
                    sb_d           = w_b_sel;
                    cnt_d          = '0;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = w_res_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d   = DONE;
                    result_d  = w_res_shift;
                    done_id_d = win_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = (win_q == C_TOP_ID) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            res_q     <= '0;
            result_q  <= '0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            res_q     <= res_d;
            result_q  <= result_d;
            done_id_q <= done_id_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = done_id_q;
    assign result  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_share_ctrl
//  Purpose  : Directed and randomized checks of xor_share_ctrl against a
//             round-robin / XOR reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xor_share_ctrl;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [WIDTH-1:0]      result;

    int        nchk  = 0;
    int        nfail = 0;
    int        ptr_m;
    logic [7:0] prev_res;
    int        prev_id;

    xor_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic reset_dut(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, " rst gnt"},     32'(gnt),     32'd0);
        chk({tag, " rst busy"},    32'(busy),    32'd0);
        chk({tag, " rst done"},    32'(done),    32'd0);
        chk({tag, " rst done_id"}, 32'(done_id), 32'd0);
        chk({tag, " rst result"},  32'(result),  32'd0);
        req  = '0;
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        rst_n    = 1'b1;
        ptr_m    = 0;
        prev_res = 8'h00;
        prev_id  = 0;
    endtask

    // Runs one job from the current IDLE state; req/a_in/b_in already driven.
    task automatic run_job(input string tag, input int chg_cyc,
                           input logic [NREQ-1:0] chg_req, input logic [NREQ*WIDTH-1:0] chg_a);
        int         w;
        logic [7:0] ea, eb, exp;
        w = rr_pick(req, ptr_m);
        if (w < 0) w = 0;
        ea  = a_in[w*WIDTH +: WIDTH];
        eb  = b_in[w*WIDTH +: WIDTH];
        exp = ea ^ eb;
        tick();
        chk({tag, " gnt"},  32'(gnt),  32'(1 << w));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " done early"}, 32'(done), 32'd0);
        for (int i = 1; i < WIDTH; i++) begin
            if (i == chg_cyc) begin
                req  = chg_req;
                a_in = chg_a;
            end
            tick();
            chk({tag, " done early"},  32'(done),    32'd0);
            chk({tag, " gnt held"},    32'(gnt),     32'(1 << w));
            chk({tag, " result held"}, 32'(result),  32'(prev_res));
            chk({tag, " id held"},     32'(done_id), 32'(prev_id));
        end
        tick();
        chk({tag, " done"},     32'(done),    32'd1);
        chk({tag, " result"},   32'(result),  32'(exp));
        chk({tag, " done_id"},  32'(done_id), 32'(w));
        chk({tag, " gnt@done"}, 32'(gnt),     32'(1 << w));
        prev_res = exp;
        prev_id  = w;
        ptr_m    = (w + 1) % NREQ;
        tick();
        chk({tag, " gnt clear"}, 32'(gnt),    32'd0);
        chk({tag, " busy clear"},32'(busy),   32'd0);
        chk({tag, " done clear"},32'(done),   32'd0);
        chk({tag, " result kept"},32'(result),32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        #3;
        reset_dut("init");

        // Single job on lane 0.
        req  = 4'b0001;
        a_in = {24'h0, 8'hA5};
        b_in = {24'h0, 8'h0F};
        run_job("single", -1, '0, '0);

        // All lanes requesting from a fresh pointer.
        reset_dut("rr");
        req  = 4'b1111;
        a_in = {8'h33, 8'h22, 8'h11, 8'h00};
        b_in = {4{8'hF0}};
        for (int j = 0; j < 5; j++) run_job("rr", -1, '0, '0);

        // Two lanes held continuously must alternate.
        req = 4'b0101;
        for (int j = 0; j < 4; j++) run_job("fair", -1, '0, '0);

        // XOR identities on lane 3.
        req  = 4'b1000;
        a_in = {8'hFF, 24'h0}; b_in = {8'hFF, 24'h0};
        run_job("ident ff", -1, '0, '0);
        a_in = {8'h00, 24'h0}; b_in = {8'h3C, 24'h0};
        run_job("ident 3c", -1, '0, '0);
        a_in = {8'h5A, 24'h0}; b_in = {8'h00, 24'h0};
        run_job("ident 5a", -1, '0, '0);

        // Reset four cycles into a lane-2 job.
        req  = 4'b0100;
        a_in = {8'h00, 8'h77, 16'h0};
        b_in = {8'h00, 8'h21, 16'h0};
        tick();
        chk("midrst gnt", 32'(gnt), 32'h4);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("midrst no done", 32'(done), 32'd0);
        end
        reset_dut("midrst");
        chk("midrst post done", 32'(done), 32'd0);
        req  = 4'b0110;
        a_in = {8'h00, 8'h12, 8'h34, 8'h00};
        b_in = {8'h00, 8'h56, 8'h78, 8'h00};
        run_job("after rst", -1, '0, '0);

        // Operand and request changes mid-job are ignored.
        reset_dut("chg");
        req  = 4'b0010;
        a_in = {16'h0, 8'h0F, 8'h0};
        b_in = {16'h0, 8'hF0, 8'h0};
        run_job("chg", 3, 4'b0000, {16'h0, 8'hFF, 8'h0});

        // Nothing requested: stays idle.
        req = '0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("idle busy", 32'(busy), 32'd0);
            chk("idle gnt",  32'(gnt),  32'd0);
        end

        // Randomized jobs with random mid-job disturbances and idle gaps.
        for (int j = 0; j < 40; j++) begin
            req  = 4'($urandom_range(1, 15));
            a_in = $urandom;
            b_in = $urandom;
            run_job("rand", int'($urandom_range(0, 9)), 4'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                tick();
                chk("rand idle busy", 32'(busy), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
